aftab_banked_memory: RTL and testbench



---
 rtl/aftab_banked_memory.sv | 203 ++++++++++++++++++++
 tb/tb_aftab_banked_memory.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/aftab_banked_memory.sv
// aftab_banked_memory
// Clocked multi-segment word memory for AFTAB core testing. numSegments
// contiguous segments of segmentSize words start at baseAddress. A request
// is latched in IDLE. After waitCycles wait states the access is performed
// and memDataReady is raised. Ready stays high until both request lines drop.
// Optional feature macro: AFTAB_MEM_ERROR_EN. When it is defined, the memError
// port reports out-of-range accesses. Otherwise out-of-range offsets wrap
// modulo the total memory size.
module aftab_banked_memory #(
    parameter int dataWidth    = 8,
    parameter int addressWidth = 32,
    parameter int numSegments  = 4,
    parameter int segmentSize  = 4096,
    parameter int baseAddress  = 0,
    parameter int waitCycles   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    readmem,
    input  logic                    writemem,
    input  logic [addressWidth-1:0] addressBus,
    input  logic [dataWidth-1:0]    dataBusIn,
    output logic [dataWidth-1:0]    dataBusOut,
    output logic                    memDataReady
`ifdef AFTAB_MEM_ERROR_EN
    ,
    output logic                    memError
`endif
);

    localparam int localBits  = $clog2(segmentSize);
    localparam int segBits    = (numSegments > 1) ? $clog2(numSegments) : 1;
    localparam int totalWords = numSegments * segmentSize;
    localparam int indexBits  = segBits + localBits;

    typedef enum logic [1:0] {
        stateIdle = 2'd0,
        stateWait = 2'd1,
        stateDone = 2'd2
    } memState_t;

    memState_t                state;
    memState_t                stateNext;
    logic [7:0]               counter;
    logic [7:0]               counterNext;
    logic [addressWidth-1:0]  latchedAddr;
    logic [addressWidth-1:0]  latchedAddrNext;
    logic [dataWidth-1:0]     latchedData;
    logic [dataWidth-1:0]     latchedDataNext;
    logic                     latchedWrite;
    logic                     latchedWriteNext;
    logic                     doAccess;

    // In IDLE the access may complete on the same edge (waitCycles == 0).
    // The live bus is therefore used there, and the latched copy is used
    // everywhere else.
    logic [addressWidth-1:0]  accessAddr;
    logic [dataWidth-1:0]     accessData;
    logic                     accessWrite;

    logic [addressWidth-1:0]  offset;
    logic [addressWidth-1:0]  segment;
    logic [segBits-1:0]       wrappedSeg;
    logic [localBits-1:0]     localIdx;
    logic [indexBits-1:0]     memIndex;
    logic [dataWidth-1:0]     readValue;
    logic                     writeEnable;

    // Storage is deliberately not reset: contents survive rst.
    logic [dataWidth-1:0]     mem [0:totalWords-1];

`ifdef AFTAB_MEM_ERROR_EN
    logic                     inRange;
`endif

    // Select the operands of the access currently being decoded.
    always_comb begin
        if (state == stateIdle) begin
            accessAddr  = addressBus;
            accessData  = dataBusIn;
            accessWrite = writemem;
        end else begin
            accessAddr  = latchedAddr;
            accessData  = latchedData;
            accessWrite = latchedWrite;
        end
    end

    // Address decode: split the offset into segment and local word.
    // Because segmentSize is a power of two, {segment, local} is the flat index.
    always_comb begin
        offset     = accessAddr - addressWidth'(baseAddress);
        segment    = offset >> localBits;
        wrappedSeg = segBits'(segment % addressWidth'(numSegments));
        localIdx   = offset[localBits-1:0];
        memIndex   = {wrappedSeg, localIdx};
`ifdef AFTAB_MEM_ERROR_EN
        inRange     = (accessAddr >= addressWidth'(baseAddress)) &&
                      (offset < addressWidth'(totalWords));
        readValue   = inRange ? mem[memIndex] : {dataWidth{1'b0}};
        writeEnable = doAccess && accessWrite && inRange;
`else
        readValue   = mem[memIndex];
        writeEnable = doAccess && accessWrite;
`endif
    end

    // Next-state logic for the IDLE / WAIT / DONE handshake.
    always_comb begin
        stateNext        = state;
        counterNext      = counter;
        latchedAddrNext  = latchedAddr;
        latchedDataNext  = latchedData;
        latchedWriteNext = latchedWrite;
        doAccess         = 1'b0;
        case (state)
            stateIdle: begin
                if (writemem || readmem) begin
                    latchedAddrNext  = addressBus;
                    latchedDataNext  = dataBusIn;
                    latchedWriteNext = writemem;
                    if (waitCycles > 0) begin
                        stateNext   = stateWait;
                        counterNext = 8'(waitCycles - 1);
                    end else begin
                        stateNext = stateDone;
                        doAccess  = 1'b1;
                    end
                end else begin
                    stateNext = stateIdle;
                end
            end
            stateWait: begin
                if (counter == 8'd0) begin
                    stateNext = stateDone;
                    doAccess  = 1'b1;
                end else begin
                    counterNext = counter - 8'd1;
                end
            end
            stateDone: begin
                if (!readmem && !writemem) begin
                    stateNext = stateIdle;
                end else begin
                    stateNext = stateDone;
                end
            end
            default: begin
                stateNext = stateIdle;
            end
        endcase
    end

    // Control state and registered outputs.
    // Reset abandons any access that has not yet reached DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= stateIdle;
            counter      <= 8'd0;
            latchedAddr  <= {addressWidth{1'b0}};
            latchedData  <= {dataWidth{1'b0}};
            latchedWrite <= 1'b0;
            dataBusOut   <= {dataWidth{1'b0}};
            memDataReady <= 1'b0;
        end else begin
            state        <= stateNext;
            counter      <= counterNext;
            latchedAddr  <= latchedAddrNext;
            latchedData  <= latchedDataNext;
            latchedWrite <= latchedWriteNext;
            memDataReady <= (stateNext == stateDone);
            if (doAccess && !accessWrite) begin
                dataBusOut <= readValue;
            end else begin
                dataBusOut <= dataBusOut;
            end
        end
    end

`ifdef AFTAB_MEM_ERROR_EN
    // Error flag: set on entering DONE for an out-of-range access and
    // cleared together with memDataReady.
    always_ff @(posedge clk) begin
        if (rst) begin
            memError <= 1'b0;
        end else if (doAccess) begin
            memError <= !inRange;
        end else if (stateNext != stateDone) begin
            memError <= 1'b0;
        end else begin
            memError <= memError;
        end
    end
`endif

    // Memory array write: happens on the edge that enters DONE, unless reset.
    always_ff @(posedge clk) begin
        if (!rst && writeEnable) begin
            mem[memIndex] <= accessData;
        end
    end

endmodule

// File: tb/tb_aftab_banked_memory.sv
// Directed testbench for aftab_banked_memory.
// dut uses waitCycles=2 and dut0 uses waitCycles=0.
module tb_aftab_banked_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        readmem, writemem;
    logic [31:0] addressBus;
    logic [7:0]  dataBusIn, dataBusOut;
    logic        memDataReady;
    logic        memError;
    logic        rd0, wr0;
    logic [31:0] addr0;
    logic [7:0]  din0, dout0;
    logic        rdy0;
    logic        err0;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int lat;

    always #5 clk = ~clk;

    aftab_banked_memory #(.waitCycles(2)) dut (
        .clk(clk), .rst(rst), .readmem(readmem), .writemem(writemem),
        .addressBus(addressBus), .dataBusIn(dataBusIn),
        .dataBusOut(dataBusOut), .memDataReady(memDataReady)
`ifdef AFTAB_MEM_ERROR_EN
        , .memError(memError)
`endif
    );

    aftab_banked_memory #(.waitCycles(0)) dut0 (
        .clk(clk), .rst(rst), .readmem(rd0), .writemem(wr0),
        .addressBus(addr0), .dataBusIn(din0),
        .dataBusOut(dout0), .memDataReady(rdy0)
`ifdef AFTAB_MEM_ERROR_EN
        , .memError(err0)
`endif
    );

`ifndef AFTAB_MEM_ERROR_EN
    assign memError = 1'b0;
    assign err0     = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge and performs one access on dut. Returns the number
    // of negedges until ready (bounded), then drops the request and checks
    // that ready falls. The task ends at a negedge with dut back in IDLE.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [7:0] d, output int latency);
        writemem   = wr;
        readmem    = rd;
        addressBus = addr;
        dataBusIn  = d;
        latency    = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (!memDataReady && latency < 20);
        writemem = 1'b0;
        readmem  = 1'b0;
        @(negedge clk);
        check("ready_drop", {31'd0, memDataReady}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        readmem = 1'b0; writemem = 1'b0; addressBus = 32'd0; dataBusIn = 8'd0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; din0 = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, memDataReady}, 32'd0);
        check("reset_dout", {24'd0, dataBusOut}, 32'd0);
        check("reset_err", {31'd0, memError}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic write and read-back with the latency check.
        access(1'b1, 1'b0, 32'h0004, 8'hA5, lat);
        check("wr_latency", lat, 3);
        check("wr_keeps_dout", {24'd0, dataBusOut}, 32'd0);
        access(1'b0, 1'b1, 32'h0004, 8'h00, lat);
        check("rd_latency", lat, 3);
        check("rd_0004", {24'd0, dataBusOut}, 32'h0000_00A5);

        // Accesses on either side of a segment boundary.
        access(1'b1, 1'b0, 32'h0FFF, 8'h11, lat);
        access(1'b1, 1'b0, 32'h1000, 8'h22, lat);
        access(1'b0, 1'b1, 32'h0FFF, 8'h00, lat);
        check("rd_0FFF", {24'd0, dataBusOut}, 32'h0000_0011);
        access(1'b0, 1'b1, 32'h1000, 8'h00, lat);
        check("rd_1000", {24'd0, dataBusOut}, 32'h0000_0022);

        // When both requests are high, the write has priority.
        access(1'b1, 1'b1, 32'h0010, 8'h5C, lat);
        check("both_latency", lat, 3);
        check("both_keeps_dout", {24'd0, dataBusOut}, 32'h0000_0022);
        access(1'b0, 1'b1, 32'h0010, 8'h00, lat);
        check("rd_0010", {24'd0, dataBusOut}, 32'h0000_005C);

        // Reset during WAIT abandons the write.
        access(1'b1, 1'b0, 32'h0020, 8'h33, lat);
        access(1'b0, 1'b1, 32'h0020, 8'h00, lat);
        check("rd_0020_pre", {24'd0, dataBusOut}, 32'h0000_0033);
        writemem = 1'b1; addressBus = 32'h0020; dataBusIn = 8'h77;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait_ready", {31'd0, memDataReady}, 32'd0);
        check("rst_wait_dout", {24'd0, dataBusOut}, 32'd0);
        rst = 1'b0;
        writemem = 1'b0;
        @(negedge clk);
        access(1'b0, 1'b1, 32'h0020, 8'h00, lat);
        check("rd_0020_post", {24'd0, dataBusOut}, 32'h0000_0033);

        // Access just past the top of memory.
        access(1'b1, 1'b0, 32'h0000, 8'h9E, lat);
`ifdef AFTAB_MEM_ERROR_EN
        readmem = 1'b1; addressBus = 32'h4000;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!memDataReady && lat < 20);
        check("oor_latency", lat, 3);
        check("oor_err", {31'd0, memError}, 32'd1);
        check("oor_dout", {24'd0, dataBusOut}, 32'd0);
        readmem = 1'b0;
        @(negedge clk);
        check("oor_err_clear", {31'd0, memError}, 32'd0);
        check("oor_ready_clear", {31'd0, memDataReady}, 32'd0);
`else
        access(1'b0, 1'b1, 32'h4000, 8'h00, lat);
        check("wrap_latency", lat, 3);
        check("wrap_4000", {24'd0, dataBusOut}, 32'h0000_009E);
`endif

        // Dropping the request during WAIT still completes the access,
        // and ready is a single-cycle pulse.
        readmem = 1'b1; addressBus = 32'h0004;
        @(negedge clk);
        readmem = 1'b0;
        @(negedge clk);
        check("drop_not_yet", {31'd0, memDataReady}, 32'd0);
        @(negedge clk);
        check("drop_pulse", {31'd0, memDataReady}, 32'd1);
        check("drop_dout", {24'd0, dataBusOut}, 32'h0000_00A5);
        @(negedge clk);
        check("drop_pulse_end", {31'd0, memDataReady}, 32'd0);

        // waitCycles = 0: ready follows one cycle after the request.
        wr0 = 1'b1; addr0 = 32'h0008; din0 = 8'h5A;
        @(negedge clk);
        check("w0_wr_ready", {31'd0, rdy0}, 32'd1);
        wr0 = 1'b0;
        @(negedge clk);
        check("w0_wr_drop", {31'd0, rdy0}, 32'd0);
        rd0 = 1'b1;
        @(negedge clk);
        check("w0_rd_data", {24'd0, dout0}, 32'h0000_005A);
        for (int i = 0; i < 5; i++) begin
            check("w0_hold_ready", {31'd0, rdy0}, 32'd1);
            if (i < 4) @(negedge clk);
        end
        rd0 = 1'b0;
        @(negedge clk);
        check("w0_hold_drop", {31'd0, rdy0}, 32'd0);
        rd0 = 1'b1;
        @(negedge clk);
        check("w0_second_ready", {31'd0, rdy0}, 32'd1);
        rd0 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
